// File: rtl/vga_pkg.sv
// Shared types and constants for the VGA timing generator.
package vga_pkg;

  typedef enum logic [1:0] {
    MODE_PASS  = 2'd0,
    MODE_GRID  = 2'd1,
    MODE_BARS  = 2'd2,
    MODE_SOLID = 2'd3
  } mode_e;

  localparam logic [23:0] BAR_RGB [8] = '{
    24'hFFFFFF, 24'hFFFF00, 24'h00FFFF, 24'h00FF00,
    24'hFF00FF, 24'hFF0000, 24'h0000FF, 24'h000000
  };

  localparam int DEF_HDISP  = 800;
  localparam int DEF_VDISP  = 480;
  localparam int DEF_HFP    = 40;
  localparam int DEF_HPULSE = 48;
  localparam int DEF_HBP    = 40;
  localparam int DEF_VFP    = 13;
  localparam int DEF_VPULSE = 3;
  localparam int DEF_VBP    = 29;

endpackage

// File: rtl/vga_pattern_gen.sv
// Per-pixel colour source selection for the stage-1 pixel; the bar index comes
// from a per-line run-length counter so no divider is needed.
module vga_pattern_gen
  import vga_pkg::*;
#(
  parameter int HDISP     = DEF_HDISP,
  parameter int XW        = 10,
  parameter int YW        = 9,
  parameter int GRID_LOG2 = 4
) (
  input  logic          pixel_clk,
  input  logic          pixel_rst,
  input  logic          act,
  input  logic [XW-1:0] x,
  input  logic [YW-1:0] y,
  input  mode_e         mode,
  input  logic [23:0]   pix_data,
  input  logic [23:0]   solid_rgb,
  output logic [23:0]   rgb
);

  localparam int          BAR_W = (HDISP / 8 > 0) ? HDISP / 8 : 1;
  localparam int          CW    = (BAR_W > 1) ? $clog2(BAR_W) : 1;
  localparam logic [31:0] GMASK = 32'((1 << GRID_LOG2) - 1);

  logic [CW-1:0] bar_cnt_r;
  logic [2:0]    bar_idx_r;
  logic [CW-1:0] bar_cnt_s;
  logic [2:0]    bar_idx_s;
  logic          grid_on_s;

  assign bar_cnt_s = (x == '0) ? '0 : bar_cnt_r;
  assign bar_idx_s = (x == '0) ? 3'd0 : bar_idx_r;
  assign grid_on_s = ((32'(x) & GMASK) == 32'd0) || ((32'(y) & GMASK) == 32'd0);

  // Run-length counter: the index holds at 7 over any remainder pixels.
  always_ff @(posedge pixel_clk) begin
    if (pixel_rst) begin
      bar_cnt_r <= '0;
      bar_idx_r <= 3'd0;
    end else if (act) begin
      if (bar_cnt_s == CW'(BAR_W - 1)) begin
        bar_cnt_r <= '0;
        bar_idx_r <= (bar_idx_s == 3'd7) ? 3'd7 : bar_idx_s + 3'd1;
      end else begin
        bar_cnt_r <= bar_cnt_s + CW'(1);
        bar_idx_r <= bar_idx_s;
      end
    end else begin
      bar_cnt_r <= bar_cnt_r;
      bar_idx_r <= bar_idx_r;
    end
  end

  always_comb begin
    rgb = 24'h000000;
    case (mode)
      MODE_PASS:  rgb = pix_data;
      MODE_GRID:  rgb = grid_on_s ? 24'hFFFFFF : 24'h000000;
      MODE_BARS:  rgb = BAR_RGB[bar_idx_s];
      MODE_SOLID: rgb = solid_rgb;
      default:    rgb = 24'h000000;
    endcase
  end

endmodule

// File: rtl/vga_timing_gen.sv
// Parametrised VGA timing generator: h/v counters, FIFO read strobe, two-stage
// output pipeline and sticky underflow detection.
module vga_timing_gen
  import vga_pkg::*;
#(
  parameter int          HDISP     = DEF_HDISP,
  parameter int          VDISP     = DEF_VDISP,
  parameter int          HFP       = DEF_HFP,
  parameter int          HPULSE    = DEF_HPULSE,
  parameter int          HBP       = DEF_HBP,
  parameter int          VFP       = DEF_VFP,
  parameter int          VPULSE    = DEF_VPULSE,
  parameter int          VBP       = DEF_VBP,
  parameter bit          HS_POL    = 1'b0,
  parameter bit          VS_POL    = 1'b0,
  parameter int          GRID_LOG2 = 4,
  parameter logic [23:0] UFLOW_RGB = 24'hFF00FF
) (
  input  logic        pixel_clk,
  input  logic        pixel_rst,
  input  logic        en,
  input  logic [1:0]  mode,
  input  logic [23:0] solid_rgb,
  output logic        pix_rd,
  input  logic [23:0] pix_data,
  input  logic        pix_empty,
  input  logic        underflow_clr,
  output logic        HS,
  output logic        VS,
  output logic        BLANK,
  output logic [23:0] RGB,
  output logic        frame_start,
  output logic        underflow,
  output logic [15:0] frame_cnt
);

  localparam int HSTART = HFP + HPULSE + HBP;
  localparam int VSTART = VFP + VPULSE + VBP;
  localparam int HTOTAL = HSTART + HDISP;
  localparam int VTOTAL = VSTART + VDISP;
  localparam int HW     = $clog2(HTOTAL);
  localparam int VW     = $clog2(VTOTAL);
  localparam int XW     = (HDISP > 1) ? $clog2(HDISP) : 1;
  localparam int YW     = (VDISP > 1) ? $clog2(VDISP) : 1;

  logic [HW-1:0] h_r;
  logic [VW-1:0] v_r;
  mode_e         mode_q_r;
  logic          h_wrap_s, v_wrap_s, act0_s, hs0_s, vs0_s;

  logic          act1_r, hs1_r, vs1_r, fs1_r, uf1_r;
  logic [XW-1:0] x1_r;
  logic [YW-1:0] y1_r;
  mode_e         mode1_r;
  logic [23:0]   pat_rgb_s;

  assign h_wrap_s = (h_r == HW'(HTOTAL - 1));
  assign v_wrap_s = (v_r == VW'(VTOTAL - 1));
  assign hs0_s    = (h_r >= HW'(HFP)) && (h_r < HW'(HFP + HPULSE));
  assign vs0_s    = (v_r >= VW'(VFP)) && (v_r < VW'(VFP + VPULSE));
  assign act0_s   = (h_r >= HW'(HSTART)) && (v_r >= VW'(VSTART));
  assign pix_rd   = act0_s && (mode_q_r == MODE_PASS) && en && !pixel_rst;

  // Stage 0: counters, frame-boundary mode capture, frame count and sticky underflow.
  always_ff @(posedge pixel_clk) begin
    if (pixel_rst) begin
      h_r       <= '0;
      v_r       <= '0;
      mode_q_r  <= MODE_PASS;
      frame_cnt <= 16'd0;
      underflow <= 1'b0;
    end else begin
      if ((h_r == '0) && (v_r == '0)) mode_q_r <= mode_e'(mode);
      if (!en) begin
        h_r <= '0;
        v_r <= '0;
      end else if (h_wrap_s) begin
        h_r <= '0;
        v_r <= v_wrap_s ? '0 : v_r + VW'(1);
      end else begin
        h_r <= h_r + HW'(1);
      end
      if (en && h_wrap_s && v_wrap_s) frame_cnt <= frame_cnt + 16'd1;
      if (pix_rd && pix_empty)        underflow <= 1'b1;
      else if (underflow_clr)         underflow <= 1'b0;
    end
  end

  // Stage 1: region flags and coordinates; gating with en drains the pipe to idle.
  always_ff @(posedge pixel_clk) begin
    if (pixel_rst) begin
      act1_r  <= 1'b0;
      hs1_r   <= 1'b0;
      vs1_r   <= 1'b0;
      fs1_r   <= 1'b0;
      uf1_r   <= 1'b0;
      x1_r    <= '0;
      y1_r    <= '0;
      mode1_r <= MODE_PASS;
    end else begin
      act1_r  <= en && act0_s;
      hs1_r   <= en && hs0_s;
      vs1_r   <= en && vs0_s;
      fs1_r   <= en && act0_s && (h_r == HW'(HSTART)) && (v_r == VW'(VSTART));
      uf1_r   <= pix_rd && pix_empty;
      x1_r    <= XW'(h_r - HW'(HSTART));
      y1_r    <= YW'(v_r - VW'(VSTART));
      mode1_r <= mode_q_r;
    end
  end

  vga_pattern_gen #(
    .HDISP     (HDISP),
    .XW        (XW),
    .YW        (YW),
    .GRID_LOG2 (GRID_LOG2)
  ) u_pattern (
    .pixel_clk (pixel_clk),
    .pixel_rst (pixel_rst),
    .act       (act1_r),
    .x         (x1_r),
    .y         (y1_r),
    .mode      (mode1_r),
    .pix_data  (pix_data),
    .solid_rgb (solid_rgb),
    .rgb       (pat_rgb_s)
  );

  // Stage 2: registered video outputs at the configured sync polarity.
  always_ff @(posedge pixel_clk) begin
    if (pixel_rst) begin
      HS          <= ~HS_POL;
      VS          <= ~VS_POL;
      BLANK       <= 1'b0;
      RGB         <= 24'h000000;
      frame_start <= 1'b0;
    end else begin
      HS          <= hs1_r ? HS_POL : ~HS_POL;
      VS          <= vs1_r ? VS_POL : ~VS_POL;
      BLANK       <= act1_r;
      RGB         <= !act1_r ? 24'h000000 : (uf1_r ? UFLOW_RGB : pat_rgb_s);
      frame_start <= fs1_r;
    end
  end

endmodule

// File: tb/tb_vga_timing_gen.sv
// Scoreboard bench: two instances (8- and 16-pixel-wide) against a behavioural
// timing model, with directed phases for every source mode, underflow, reset and en.
module tb_vga_timing_gen;

  typedef struct packed {
    logic        hs;
    logic        vs;
    logic        blank;
    logic        fs;
    logic [23:0] rgb;
  } exp_t;

  typedef struct {
    int h;
    int v;
    int mq;
    int frames;
    int rdidx;
    bit uf;
  } model_t;

  localparam exp_t IDLE_E = '{hs: 1'b1, vs: 1'b1, blank: 1'b0, fs: 1'b0, rgb: 24'h000000};

  logic        clk;
  logic        pixel_rst, en, pix_empty, underflow_clr;
  logic [1:0]  mode;
  logic [23:0] solid_rgb;
  logic [23:0] pdata [2];
  wire  [1:0]  rd_w, hs_w, vs_w, blank_w, fs_w, uf_w;
  wire  [23:0] rgb_w [2];
  wire  [15:0] fc_w [2];

  int          n_cmp = 0;
  int          n_fail = 0;
  int          hd [2] = '{8, 16};
  int          fifo [2];
  model_t      m [2];
  exp_t        q0 [$];
  exp_t        q1 [$];
  logic [23:0] bars [8] = '{24'hFFFFFF, 24'hFFFF00, 24'h00FFFF, 24'h00FF00,
                            24'hFF00FF, 24'hFF0000, 24'h0000FF, 24'h000000};
  bit          rd_seen [2];
  bit          rd_cnt_on, hit1, hit2;
  int          rd_count = 0;

  vga_timing_gen #(.HDISP(8), .VDISP(4), .HFP(2), .HPULSE(2), .HBP(2),
                   .VFP(1), .VPULSE(1), .VBP(1), .GRID_LOG2(2)) dut8 (
    .pixel_clk(clk), .pixel_rst(pixel_rst), .en(en), .mode(mode), .solid_rgb(solid_rgb),
    .pix_rd(rd_w[0]), .pix_data(pdata[0]), .pix_empty(pix_empty), .underflow_clr(underflow_clr),
    .HS(hs_w[0]), .VS(vs_w[0]), .BLANK(blank_w[0]), .RGB(rgb_w[0]),
    .frame_start(fs_w[0]), .underflow(uf_w[0]), .frame_cnt(fc_w[0]));

  vga_timing_gen #(.HDISP(16), .VDISP(4), .HFP(2), .HPULSE(2), .HBP(2),
                   .VFP(1), .VPULSE(1), .VBP(1), .GRID_LOG2(2)) dut16 (
    .pixel_clk(clk), .pixel_rst(pixel_rst), .en(en), .mode(mode), .solid_rgb(solid_rgb),
    .pix_rd(rd_w[1]), .pix_data(pdata[1]), .pix_empty(pix_empty), .underflow_clr(underflow_clr),
    .HS(hs_w[1]), .VS(vs_w[1]), .BLANK(blank_w[1]), .RGB(rgb_w[1]),
    .frame_start(fs_w[1]), .underflow(uf_w[1]), .frame_cnt(fc_w[1]));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(string tag, logic [31:0] obs, logic [31:0] expv);
    n_cmp++;
    assert (obs === expv) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
    end
  endtask

  // One pixel clock: predict, check pix_rd, advance, then check registered outputs.
  task automatic tick();
    exp_t e;
    bit   pr, act;
    int   x, y, bi;
    #4;
    for (int k = 0; k < 2; k++) begin
      act = (m[k].h >= 6) && (m[k].v >= 3);
      x   = m[k].h - 6;
      y   = m[k].v - 3;
      pr  = !pixel_rst && en && act && (m[k].mq == 0);
      chk($sformatf("pix_rd%0d", hd[k]), 32'(rd_w[k]), 32'(pr));
      rd_seen[k] = (rd_w[k] === 1'b1);
      if (k == 0 && rd_cnt_on && rd_seen[0]) rd_count++;
      if (pixel_rst) begin
        if (k == 0) begin q0.delete(); q0.push_back(IDLE_E); q0.push_back(IDLE_E); end
        else        begin q1.delete(); q1.push_back(IDLE_E); q1.push_back(IDLE_E); end
        m[k].h = 0; m[k].v = 0; m[k].mq = 0; m[k].frames = 0; m[k].uf = 1'b0;
      end else begin
        e = IDLE_E;
        if (en) begin
          e.hs    = !((m[k].h >= 2) && (m[k].h < 4));
          e.vs    = !(m[k].v == 1);
          e.blank = act;
          e.fs    = act && (x == 0) && (y == 0);
          if (act) begin
            case (m[k].mq)
              0: e.rgb = (pr && pix_empty) ? 24'hFF00FF : 24'(m[k].rdidx);
              1: e.rgb = ((x % 4 == 0) || (y % 4 == 0)) ? 24'hFFFFFF : 24'h000000;
              2: begin bi = x / (hd[k] / 8); if (bi > 7) bi = 7; e.rgb = bars[bi]; end
              default: e.rgb = solid_rgb;
            endcase
          end
        end
        if (k == 0) q0.push_back(e); else q1.push_back(e);
        if (pr && !pix_empty) m[k].rdidx++;
        if (pr && pix_empty)    m[k].uf = 1'b1;
        else if (underflow_clr) m[k].uf = 1'b0;
        if (m[k].h == 0 && m[k].v == 0) m[k].mq = int'(mode);
        if (!en) begin
          m[k].h = 0; m[k].v = 0;
        end else if (m[k].h == 6 + hd[k] - 1) begin
          m[k].h = 0;
          if (m[k].v == 6) begin m[k].v = 0; m[k].frames = (m[k].frames + 1) % 65536; end
          else m[k].v++;
        end else begin
          m[k].h++;
        end
      end
    end
    @(posedge clk);
    #1;
    for (int k = 0; k < 2; k++) begin
      if (rd_seen[k] && !pix_empty) begin pdata[k] = 24'(fifo[k]); fifo[k]++; end
      e = (k == 0) ? q0.pop_front() : q1.pop_front();
      chk($sformatf("HS%0d", hd[k]),          32'(hs_w[k]),    32'(e.hs));
      chk($sformatf("VS%0d", hd[k]),          32'(vs_w[k]),    32'(e.vs));
      chk($sformatf("BLANK%0d", hd[k]),       32'(blank_w[k]), 32'(e.blank));
      chk($sformatf("RGB%0d", hd[k]),         32'(rgb_w[k]),   32'(e.rgb));
      chk($sformatf("frame_start%0d", hd[k]), 32'(fs_w[k]),    32'(e.fs));
      chk($sformatf("frame_cnt%0d", hd[k]),   32'(fc_w[k]),    32'(m[k].frames));
      chk($sformatf("underflow%0d", hd[k]),   32'(uf_w[k]),    32'(m[k].uf));
    end
  endtask

  initial begin
    pixel_rst = 1'b1; en = 1'b0; mode = 2'd1; solid_rgb = 24'h000000;
    pix_empty = 1'b0; underflow_clr = 1'b0; rd_cnt_on = 1'b0;
    pdata[0] = 24'h0; pdata[1] = 24'h0; fifo[0] = 0; fifo[1] = 0;
    m[0].rdidx = 0; m[1].rdidx = 0;
    repeat (2) tick();
    chk("rst_frame_cnt", 32'(fc_w[0]), 32'd0);

    // Grid frame from reset.
    pixel_rst = 1'b0; en = 1'b1;
    repeat (98) tick();
    chk("frame_cnt_98", 32'(fc_w[0]), 32'd1);

    // Passthrough with one underflow, a clear, and a clear colliding with a set.
    mode = 2'd0;
    for (int i = 0; i < 400; i++) begin
      hit1 = (i < 98) && (m[0].h == 9) && (m[0].v == 4);
      hit2 = (i >= 200) && (i < 294) && (m[0].h == 10) && (m[0].v == 5);
      pix_empty     = hit1 || hit2;
      underflow_clr = (i == 150) || hit2;
      rd_cnt_on     = (i < 98);
      tick();
      if (hit1)     chk("uflow_set", 32'(uf_w[0]), 32'd1);
      if (i == 150) chk("uflow_clr", 32'(uf_w[0]), 32'd0);
      if (hit2)     chk("uflow_set_wins", 32'(uf_w[0]), 32'd1);
    end
    pix_empty = 1'b0; underflow_clr = 1'b0; rd_cnt_on = 1'b0;
    chk("rd_per_frame", 32'(rd_count), 32'd32);

    mode = 2'd2;
    repeat (400) tick();

    mode = 2'd3; solid_rgb = 24'h123456;
    repeat (200) tick();
    mode = 2'd1;
    repeat (200) tick();

    // Reset mid-line, then en dropped mid-frame.
    repeat (5) tick();
    pixel_rst = 1'b1;
    tick();
    chk("rst_blank", 32'(blank_w[0]), 32'd0);
    chk("rst_hs", 32'(hs_w[0]), 32'd1);
    pixel_rst = 1'b0;
    repeat (60) tick();
    en = 1'b0;
    repeat (3) tick();
    chk("idle_blank", 32'(blank_w[1]), 32'd0);
    chk("idle_rgb", 32'(rgb_w[1]), 32'd0);
    en = 1'b1;
    repeat (200) tick();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
